// File: rtl/dsec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsec_sequencer
// Description : Block-level sequencer for the DSEC top level. It hands each
//               accepted input block to the compression core and then to the
//               encryption core, and holds the result until the receiver
//               acknowledges it. It also gates key-configuration sessions and
//               latches a 64-bit error record on every entry to ERR.
//               Optional feature macro: DSEC_TIMEOUT_EN enables a per-stage
//               watchdog on COMP, ENCRY and OUT.
// Revision    : 1.0 - initial release
// ============================================================================
module dsec_sequencer #(
    parameter int KEY_WORDS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        key_config,
    input  logic        key_word_valid,
    output logic        key_load,
    input  logic        in_valid,
    output logic        rdy,
    input  logic        comp_rdy,
    output logic        comp_start,
    input  logic        comp_done,
    input  logic        comp_err,
    input  logic        encry_rdy,
    output logic        encry_start,
    input  logic        encry_done,
    output logic        out_valid,
    input  logic        out_rcvd,
    output logic        stall,
    output logic        error,
    output logic [63:0] error_code,
    input  logic        err_clr,
    output logic [31:0] blk_count
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_KEYCFG = 3'd1;
    localparam logic [2:0] c_COMP   = 3'd2;
    localparam logic [2:0] c_ENCRY  = 3'd3;
    localparam logic [2:0] c_OUT    = 3'd4;
    localparam logic [2:0] c_ERR    = 3'd5;

    localparam logic [7:0]  c_KEY_LAST = 8'(KEY_WORDS - 1);
    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    generate
        if ((KEY_WORDS < 1) || (KEY_WORDS > 255)) begin : g_bad_key_words
            $error("dsec_sequencer: KEY_WORDS must be in 1..255");
        end
        if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_timeout
            $error("dsec_sequencer: TIMEOUT_CYCLES must be in 2..65536");
        end
    endgenerate

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  w_err_code;
    logic [7:0]  r_key_cnt;
    logic        r_comp_start;
    logic        r_encry_start;
    logic        r_out_valid;
    logic        r_error;
    logic [63:0] r_error_code;
    logic [31:0] r_blk_count;
    logic        w_rdy;
    logic        w_key_load;
    logic        w_stall;
    logic [7:0]  w_onehot;
    logic        w_key_last;
    logic        w_timeout;
    logic [15:0] w_stg_cnt;

    assign w_key_last = (r_key_cnt == c_KEY_LAST);

`ifdef DSEC_TIMEOUT_EN
    logic [15:0] r_stg_cnt;

    // Stage watchdog: restarts on every state change, counts while in a stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_stg_cnt <= 16'd0;
        end else if ((r_state == c_COMP) || (r_state == c_ENCRY) || (r_state == c_OUT)) begin
            r_stg_cnt <= r_stg_cnt + 16'd1;
        end
    end

    assign w_stg_cnt = r_stg_cnt;
    assign w_timeout = (r_stg_cnt == c_TO_LAST);
`else
    // Without the watchdog, stages wait indefinitely and the record field is zero.
    assign w_stg_cnt = 16'd0;
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; exit events take priority over the watchdog.
    always_comb begin
        w_next     = r_state;
        w_err_code = 8'h00;
        case (r_state)
            c_IDLE: begin
                if (key_config) begin
                    w_next = c_KEYCFG;
                end else if (in_valid && w_rdy) begin
                    w_next = c_COMP;
                end
            end
            c_KEYCFG: begin
                if (key_word_valid && w_key_last) begin
                    w_next = c_IDLE;
                end else if (!key_config) begin
                    w_next     = c_ERR;
                    w_err_code = 8'h02;
                end
            end
            c_COMP: begin
                if (comp_err) begin
                    w_next     = c_ERR;
                    w_err_code = 8'h01;
                end else if (comp_done) begin
                    w_next = c_ENCRY;
                end else if (w_timeout) begin
                    w_next     = c_ERR;
                    w_err_code = 8'h03;
                end
            end
            c_ENCRY: begin
                if (encry_done) begin
                    w_next = c_OUT;
                end else if (w_timeout) begin
                    w_next     = c_ERR;
                    w_err_code = 8'h04;
                end
            end
            c_OUT: begin
                if (out_rcvd) begin
                    w_next = c_IDLE;
                end else if (w_timeout) begin
                    w_next     = c_ERR;
                    w_err_code = 8'h05;
                end
            end
            c_ERR: begin
                if (err_clr) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Combinational outputs and the one-hot tag of the current state.
    always_comb begin
        w_rdy      = (r_state == c_IDLE) && comp_rdy && encry_rdy && !key_config;
        w_key_load = (r_state == c_KEYCFG) && key_word_valid;
        w_stall    = ((r_state == c_IDLE) && !in_valid) ||
                     (r_state == c_KEYCFG) ||
                     (r_state == c_ERR) ||
                     ((r_state == c_OUT) && !out_rcvd);
        case (r_state)
            c_IDLE:   w_onehot = 8'h01;
            c_KEYCFG: w_onehot = 8'h02;
            c_COMP:   w_onehot = 8'h04;
            c_ENCRY:  w_onehot = 8'h08;
            c_OUT:    w_onehot = 8'h10;
            default:  w_onehot = 8'h00;
        endcase
    end

    // Registered strobes/flags, error record capture and block counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_comp_start  <= 1'b0;
            r_encry_start <= 1'b0;
            r_out_valid   <= 1'b0;
            r_error       <= 1'b0;
            r_error_code  <= 64'd0;
            r_blk_count   <= 32'd0;
        end else begin
            r_comp_start  <= (w_next == c_COMP)  && (r_state != c_COMP);
            r_encry_start <= (w_next == c_ENCRY) && (r_state != c_ENCRY);
            r_out_valid   <= (w_next == c_OUT);
            r_error       <= (w_next == c_ERR);
            if ((w_next == c_ERR) && (r_state != c_ERR)) begin
                r_error_code <= {w_err_code, w_onehot, w_stg_cnt, r_blk_count};
            end
            if ((r_state == c_OUT) && out_rcvd) begin
                r_blk_count <= r_blk_count + 32'd1;
            end
        end
    end

    // Key word counter; any exit from KEYCFG starts the next session at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_cnt <= 8'd0;
        end else if (r_state == c_KEYCFG) begin
            if (w_next != c_KEYCFG) begin
                r_key_cnt <= 8'd0;
            end else if (key_word_valid) begin
                r_key_cnt <= r_key_cnt + 8'd1;
            end
        end
    end

    assign rdy         = w_rdy;
    assign key_load    = w_key_load;
    assign stall       = w_stall;
    assign comp_start  = r_comp_start;
    assign encry_start = r_encry_start;
    assign out_valid   = r_out_valid;
    assign error       = r_error;
    assign error_code  = r_error_code;
    assign blk_count   = r_blk_count;

endmodule
`default_nettype wire
